// File: rtl/seg7_scan_decoder.sv
// Decodes a multiplexed, active-high 7-segment scan bus back into per-digit values.
// Each {seg, an} sample must hold for STABLE_CYCLES before it is captured into the digit store.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  seg_in,
  input  logic [7:0]  an_in,
  output logic [31:0] digits_out,
  output logic [7:0]  dp_out,
  output logic [7:0]  err_out,
  output logic        frame_valid,
  output logic        bad_select
);

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 1);

  logic [15:0] sample_q, sample_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  mask_q, mask_d;
  logic [31:0] digits_q, digits_d;
  logic [7:0]  dp_q, dp_d;
  logic [7:0]  err_q, err_d;
  logic        frame_valid_q, frame_valid_d;
  logic        bad_select_q, bad_select_d;

  logic        same;
  logic        capture;
  logic        one_hot;
  logic [6:0]  seg_pat;
  logic        dp_bit;
  logic [7:0]  an_sel;
  logic [3:0]  dec_val;
  logic        dec_err;

  // Stability tracking: the counter reaches CNT_CAP only after an unbroken run of equal samples.
  always_comb begin
    sample_d = {seg_in, an_in};
    same     = (sample_d == sample_q);
    if (!same)                cnt_d = 8'd0;
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                      cnt_d = cnt_q + 8'd1;
    capture  = same && (cnt_q == CNT_CAP);
  end

  // Decode the held sample; it equals the live input whenever capture is true.
  always_comb begin
    seg_pat = sample_q[15:9];
    dp_bit  = sample_q[8];
    an_sel  = sample_q[7:0];
    one_hot = (an_sel != 8'd0) && ((an_sel & (an_sel - 8'd1)) == 8'd0);
    dec_err = 1'b0;
    case (seg_pat)
      7'b1111110: dec_val = 4'h0;
      7'b0110000: dec_val = 4'h1;
      7'b1101101: dec_val = 4'h2;
      7'b1111001: dec_val = 4'h3;
      7'b0110011: dec_val = 4'h4;
      7'b1011011: dec_val = 4'h5;
      7'b1011111: dec_val = 4'h6;
      7'b1110000: dec_val = 4'h7;
      7'b1111111: dec_val = 4'h8;
      7'b1111011: dec_val = 4'h9;
      7'b0000000: dec_val = 4'hF;
      default: begin
        dec_val = 4'hF;
        dec_err = 1'b1;
      end
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    digits_d      = digits_q;
    dp_d          = dp_q;
    err_d         = err_q;
    bad_select_d  = 1'b0;
    frame_valid_d = (mask_q == 8'hFF);
    mask_d        = frame_valid_d ? 8'h00 : mask_q;
    if (capture) begin
      if (one_hot) begin
        for (int i = 0; i < 8; i++) begin
          if (an_sel[i]) begin
            digits_d[4*i +: 4] = dec_val;
            dp_d[i]            = dp_bit;
            err_d[i]           = dec_err;
          end
        end
        mask_d = mask_d | an_sel;
      end else if (an_sel != 8'd0) begin
        bad_select_d = 1'b1;
      end
    end
  end

  // NOTE: state updates use non-blocking assignments; reset is asynchronous and clears every flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q      <= '0;
      cnt_q         <= '0;
      mask_q        <= '0;
      digits_q      <= 32'hFFFF_FFFF;
      dp_q          <= '0;
      err_q         <= '0;
      frame_valid_q <= 1'b0;
      bad_select_q  <= 1'b0;
    end else begin
      sample_q      <= sample_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      digits_q      <= digits_d;
      dp_q          <= dp_d;
      err_q         <= err_d;
      frame_valid_q <= frame_valid_d;
      bad_select_q  <= bad_select_d;
    end
  end

  assign digits_out  = digits_q;
  assign dp_out      = dp_q;
  assign err_out     = err_q;
  assign frame_valid = frame_valid_q;
  assign bad_select  = bad_select_q;

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 The block SHALL have one parameter: STABLE_CYCLES, default 4, the number of consecutive cycles an input sample must hold before it is captured (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port seg_in, input, 8 bits, active-high segment pattern: bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp.
REQ-005 The block SHALL have port an_in, input, 8 bits, active-high digit select; bit i selects digit i; it is expected to be one-hot or zero.
REQ-006 The block SHALL have port digits_out, output, 32 bits, decoded digit i held in bits [4i+3:4i].
REQ-007 The block SHALL have port dp_out, output, 8 bits, captured dp bit per digit.
REQ-008 The block SHALL have port err_out, output, 8 bits, per-digit flag for an unrecognised segment pattern.
REQ-009 The block SHALL have port frame_valid, output, 1 bit, one-cycle pulse when all 8 digits have been captured since the previous pulse.
REQ-010 The block SHALL have port bad_select, output, 1 bit, one-cycle pulse when a stable an_in is neither zero nor one-hot.

Function
REQ-011 The block SHALL register {seg_in, an_in} into a sample register each cycle; a sample differing from the held one SHALL reset the stability counter to 0, and an equal sample SHALL increment it, saturating at STABLE_CYCLES.
REQ-012 A capture event SHALL occur on the edge where the counter equals STABLE_CYCLES-1 and the sample is unchanged; exactly one event per stable period. With a held input, outputs update after edge STABLE_CYCLES+1 counted from the first edge registering the new input.
REQ-013 On a capture event with one-hot an_in, bit i, the block SHALL decode seg_in[7:1] and write digit i, dp_out[i]=seg_in[0], and err_out[i]; all other digits SHALL be unchanged.
REQ-014 The decode table (seg_in[7:1] -> digit) SHALL be: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9. The dp bit SHALL NOT affect decoding.
REQ-015 Pattern 0000000 (blank) SHALL decode to 4'hF with err_out[i]=0; any other pattern not in the table SHALL decode to 4'hF with err_out[i]=1.
REQ-016 A capture event with an_in==0 SHALL change nothing (blanking interval).
REQ-017 A capture event with an_in neither zero nor one-hot SHALL change no digit state and SHALL pulse bad_select high for exactly the next cycle.
REQ-018 The block SHALL keep an 8-bit seen mask; each one-hot capture SHALL set bit i; recapturing an already-set digit SHALL overwrite its value and leave the mask unchanged.
REQ-019 When the mask becomes all ones, frame_valid SHALL be high for exactly one cycle, on the cycle after the completing capture, and the mask SHALL clear on that same edge; a capture coinciding with the clear SHALL leave only its own bit set.
REQ-020 frame_valid and bad_select SHALL be registered outputs; digits_out, dp_out and err_out SHALL hold their values between capture events.

Reset
REQ-021 While rst_n is low, the block SHALL immediately force digits_out=32'hFFFF_FFFF, dp_out=8'h00, err_out=8'h00, frame_valid=0 and bad_select=0, and clear the sample register, counter and mask, independent of clk.
REQ-022 Reset asserted mid-stability or mid-frame SHALL discard the partial capture and partial mask; after release, capture SHALL restart per REQ-011.

Verification
REQ-023 Scenario: STABLE_CYCLES=4, hold seg_in=8'b11011010, an_in=8'h04 -> digits_out[11:8]=4'h2 after the 5th edge, dp_out[2]=0, err_out[2]=0, other digits remain 4'hF.
REQ-024 Scenario: drive digits 0..7 in turn with patterns for 0..7, each held 6 cycles -> digits_out=32'h7654_3210; frame_valid pulses once, one cycle after the digit-7 capture; the mask then starts empty.
REQ-025 Scenario: seg_in toggles every 2 cycles with STABLE_CYCLES=4 -> no capture and outputs unchanged; then hold 8'b01100001 on an_in=8'h01 -> digit 0=1, dp_out[0]=1.
REQ-026 Scenario: hold seg_in=8'b10010010, an_in=8'h80 -> digits_out[31:28]=4'hF, err_out[7]=1; hold an_in=8'h18 -> one bad_select pulse and no state change.
REQ-027 Scenario: assert rst_n low between clock edges after 5 digits are captured -> outputs return to reset values immediately; a full 8-digit scan is then needed before frame_valid pulses.
REQ-028 Scenario: hold an_in=8'h00 with any seg_in for 20 cycles -> no output change and no pulses.
